mppt_controller: RTL and testbench
==================================

MPPT_CONTROLLER -- requirements
Module: mppt_controller

Interface
REQ-001 SHALL provide parameter STEP, default 4, duty perturbation size per iteration (LSBs).
REQ-002 SHALL provide parameter DUTY_MIN, default 16, lowest permitted duty code.
REQ-003 SHALL provide parameter DUTY_MAX, default 240, highest permitted duty code.
REQ-004 SHALL provide parameter DUTY_INIT, default 128, duty code after reset.
REQ-005 SHALL provide parameter SETTLE, default 64, converter settle time in clk cycles after each duty change (min 1).
REQ-006 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-008 SHALL have port ena  input  1  controller enable.
REQ-009 SHALL have port v_sample  input  8  unsigned panel voltage sample.
REQ-010 SHALL have port i_sample  input  8  unsigned panel current sample.
REQ-011 SHALL have port sample_valid  input  1  sample pair valid.
REQ-012 SHALL have port sample_ready  output  1  controller accepts a sample pair.
REQ-013 SHALL have port duty  output  8  registered PWM duty code to the converter.
REQ-014 SHALL have port duty_update  output  1  one-cycle pulse when duty changes value or is re-evaluated.
REQ-015 SHALL have port power  output  16  last computed v_sample*i_sample.
REQ-016 SHALL have port dir  output  1  perturbation direction, 1 = increase.
REQ-017 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, ACQUIRE, COMPUTE, DECIDE.
REQ-019 IDLE: ena=1 -> SETTLE with settle counter cleared; otherwise stay.
REQ-020 SETTLE: count SETTLE cycles, then -> ACQUIRE.
REQ-021 ACQUIRE: sample_ready=1 (registered, only in this state); sample_valid&sample_ready on an edge captures both samples and -> COMPUTE; sample_valid without ready is ignored.
REQ-022 COMPUTE: power <= v*i (full 16-bit, no truncation) on exit edge; -> DECIDE.
REQ-023 DECIDE: if power < p_prev, dir toggles; if power >= p_prev, dir holds (equality keeps direction).
REQ-024 DECIDE: duty <= duty +/- STEP per new dir, saturated to [DUTY_MIN, DUTY_MAX]; if saturation clipped the step, dir toggles again for the next iteration; p_prev <= power; -> SETTLE.
REQ-025 Latency: handshake on edge k -> power valid after edge k+1 -> duty valid and duty_update high for exactly the cycle after edge k+2.
REQ-026 ena=0 in any non-IDLE state -> IDLE on next edge; duty, dir, power, p_prev retained; sample_ready low from that edge; no duty_update.
REQ-027 ena re-asserted always restarts a full SETTLE period.
REQ-028 First iteration after reset compares against p_prev=0, so dir stays 1.

Reset
REQ-029 rst_n=0 SHALL immediately, without clk: state=IDLE, duty=DUTY_INIT, dir=1, power=0, p_prev=0, settle counter=0, sample_ready=0, duty_update=0, busy=0.
REQ-030 Reset mid-operation SHALL discard any captured sample; no duty_update pulse on release.

Structure
REQ-031 Shared package mppt_pkg SHALL hold the FSM state enum and default constants (STEP, DUTY_MIN, DUTY_MAX, DUTY_INIT, SETTLE).
REQ-032 Settle counting SHALL be a sub-module mppt_settle_timer (start, done pulse, width from SETTLE).
REQ-033 All outputs SHALL be registered; no combinational path input->output.

Verification (SETTLE=4 in bench)
REQ-034 Reset: rst_n low mid-COMPUTE -> duty=128, power=0, dir=1, sample_ready=0, busy=0 without clock edge.
REQ-035 First cycle: ena=1, v=150, i=85 handshake -> power=12750, duty=132, dir=1, one duty_update pulse 2 edges after handshake.
REQ-036 Power drop: next sample v=45, i=85 -> power=3825, dir=0, duty=128.
REQ-037 Saturation: duty=238, dir=1, power rising -> duty=240, dir=0; next rising power -> duty=236.
REQ-038 ena dropped in ACQUIRE -> sample_ready low next cycle, duty unchanged, no pulse; re-enable -> 4 SETTLE cycles before sample_ready.
REQ-039 Equal power: repeat v=150, i=85 -> dir unchanged, duty steps same direction.

Source files
------------

// File: rtl/mppt_pkg.sv
// Shared types and default constants for the perturb-and-observe MPPT controller.
package mppt_pkg;

  localparam int unsigned StepDefault     = 4;
  localparam int unsigned DutyMinDefault  = 16;
  localparam int unsigned DutyMaxDefault  = 240;
  localparam int unsigned DutyInitDefault = 128;
  localparam int unsigned SettleDefault   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAcquire,
    StCompute,
    StDecide
  } mppt_state_e;

endpackage

// File: rtl/mppt_if.sv
// Sample-pair handshake between the panel ADC front end and the MPPT controller.
interface mppt_if;
  logic [7:0] v_sample;
  logic [7:0] i_sample;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output v_sample,
    output i_sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  v_sample,
    input  i_sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/mppt_settle_timer.sv
// Counts SETTLE cycles after start; done is high in the last cycle of the period.
module mppt_settle_timer
  import mppt_pkg::*;
#(
  parameter int unsigned SETTLE = SettleDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic done
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE - 1);

  logic [CntW-1:0] cnt_q;
  logic            run_q;

  assign done = run_q && (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (done) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mppt_controller.sv
// Perturb-and-observe MPPT: settle, sample V/I, compute power, step duty toward rising power.
module mppt_controller
  import mppt_pkg::*;
#(
  parameter int unsigned STEP      = StepDefault,
  parameter int unsigned DUTY_MIN  = DutyMinDefault,
  parameter int unsigned DUTY_MAX  = DutyMaxDefault,
  parameter int unsigned DUTY_INIT = DutyInitDefault,
  parameter int unsigned SETTLE    = SettleDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  mppt_if.slave       smp,
  output logic [7:0]  duty,
  output logic        duty_update,
  output logic [15:0] power,
  output logic        dir,
  output logic        busy
);

  mppt_state_e state_q, state_d;

  logic [7:0]  v_q, i_q;
  logic [15:0] power_q, p_prev_q;
  logic [7:0]  duty_q;
  logic        dir_q;
  logic        sample_ready_q;
  logic        duty_update_q;
  logic        busy_q;

  logic settle_start;
  logic settle_done;
  logic handshake;

  logic              dir_new;
  logic signed [9:0] duty_tgt;
  logic [7:0]        duty_sat;
  logic              clipped;

  mppt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(settle_start),
    .abort(!ena),
    .done (settle_done)
  );

  assign handshake = smp.sample_valid && sample_ready_q;

  always_comb begin
    state_d      = state_q;
    settle_start = 1'b0;
    if (!ena) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d      = StSettle;
          settle_start = 1'b1;
        end
        StSettle:  if (settle_done) state_d = StAcquire;
        StAcquire: if (handshake) state_d = StCompute;
        StCompute: state_d = StDecide;
        StDecide: begin
          state_d      = StSettle;
          settle_start = 1'b1;
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  // Falling power reverses the search; a clipped step reverses it once more.
  always_comb begin
    dir_new  = dir_q ^ (power_q < p_prev_q);
    duty_tgt = dir_new ? $signed({2'b00, duty_q}) + $signed(10'(STEP))
                       : $signed({2'b00, duty_q}) - $signed(10'(STEP));
    duty_sat = duty_tgt[7:0];
    clipped  = 1'b0;
    if (duty_tgt > $signed(10'(DUTY_MAX))) begin
      duty_sat = 8'(DUTY_MAX);
      clipped  = 1'b1;
    end else if (duty_tgt < $signed(10'(DUTY_MIN))) begin
      duty_sat = 8'(DUTY_MIN);
      clipped  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q            <= '0;
      i_q            <= '0;
      power_q        <= '0;
      p_prev_q       <= '0;
      duty_q         <= 8'(DUTY_INIT);
      dir_q          <= 1'b1;
      sample_ready_q <= 1'b0;
      duty_update_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sample_ready_q <= (state_d == StAcquire);
      busy_q         <= (state_d != StIdle);
      duty_update_q  <= 1'b0;
      if (ena && state_q == StAcquire && handshake) begin
        v_q <= smp.v_sample;
        i_q <= smp.i_sample;
      end
      if (ena && state_q == StCompute) begin
        power_q <= 16'(v_q) * 16'(i_q);
      end
      if (ena && state_q == StDecide) begin
        duty_q        <= duty_sat;
        dir_q         <= dir_new ^ clipped;
        p_prev_q      <= power_q;
        duty_update_q <= 1'b1;
      end
    end
  end

  assign smp.sample_ready = sample_ready_q;
  assign duty             = duty_q;
  assign duty_update      = duty_update_q;
  assign power            = power_q;
  assign dir              = dir_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_mppt_controller.sv
// Randomized bench for mppt_controller against a behavioural hill-climbing model.
module tb_mppt_controller;

  localparam int Settle   = 4;
  localparam int Step     = 4;
  localparam int DutyMin  = 16;
  localparam int DutyMax  = 240;
  localparam int DutyInit = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  duty;
  logic        duty_update;
  logic [15:0] power;
  logic        dir;
  logic        busy;

  mppt_if smp ();

  mppt_controller #(
    .SETTLE(Settle)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .smp        (smp),
    .duty       (duty),
    .duty_update(duty_update),
    .power      (power),
    .dir        (dir),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_duty, m_dir, m_pprev, m_power;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_duty  = DutyInit;
    m_dir   = 1;
    m_pprev = 0;
    m_power = 0;
  endtask

  // Hill-climb rule: reverse on lower power, step, and bounce off the duty limits.
  task automatic model_step(input int pw);
    int t;
    m_power = pw;
    if (pw < m_pprev) m_dir = 1 - m_dir;
    t = (m_dir == 1) ? m_duty + Step : m_duty - Step;
    if (t > DutyMax) begin
      t     = DutyMax;
      m_dir = 1 - m_dir;
    end else if (t < DutyMin) begin
      t     = DutyMin;
      m_dir = 1 - m_dir;
    end
    m_duty  = t;
    m_pprev = pw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered SETTLE; junk valids must be ignored meanwhile.
  task automatic wait_settle();
    int n = 0;
    while (!smp.sample_ready && n < 200) begin
      smp.sample_valid = 1'($urandom_range(0, 1));
      smp.v_sample     = 8'($urandom);
      smp.i_sample     = 8'($urandom);
      tick();
      n++;
      if (n == 1) check_eq("pulse_width", duty_update, 0);
    end
    smp.sample_valid = 1'b0;
    check_eq("settle_len", n, Settle);
    check_eq("power_hold", power, m_power);
  endtask

  task automatic start_run();
    ena = 1'b1;
    tick();
    check_eq("busy_on", busy, 1);
    check_eq("ready_settle", smp.sample_ready, 0);
  endtask

  task automatic run_iter(input logic [7:0] v, input logic [7:0] i);
    int gap;
    wait_settle();
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      tick();
      check_eq("ready_hold", smp.sample_ready, 1);
    end
    smp.v_sample     = v;
    smp.i_sample     = i;
    smp.sample_valid = 1'b1;
    tick();
    smp.sample_valid = 1'b0;
    smp.v_sample     = 8'($urandom);
    smp.i_sample     = 8'($urandom);
    check_eq("ready_drop", smp.sample_ready, 0);
    check_eq("no_early_pulse", duty_update, 0);
    tick();
    check_eq("power", power, int'(v) * int'(i));
    check_eq("duty_before", duty, m_duty);
    model_step(int'(v) * int'(i));
    tick();
    check_eq("duty", duty, m_duty);
    check_eq("dir", dir, m_dir);
    check_eq("pulse", duty_update, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    ena   = 1'b0;
    smp.sample_valid = 1'b0;
    smp.v_sample     = '0;
    smp.i_sample     = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_duty", duty, DutyInit);
    check_eq("rst_power", power, 0);
    check_eq("rst_dir", dir, 1);
    check_eq("rst_ready", smp.sample_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulse", duty_update, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      tick();
      check_eq("idle_busy", busy, 0);
      check_eq("idle_ready", smp.sample_ready, 0);
    end

    // Directed climb: first step, power drop, recovery, equal power.
    start_run();
    run_iter(8'd150, 8'd85);
    check_eq("first_duty", duty, 132);
    run_iter(8'd45, 8'd85);
    check_eq("drop_duty", duty, 128);
    check_eq("drop_dir", dir, 0);
    run_iter(8'd150, 8'd85);
    run_iter(8'd150, 8'd85);
    check_eq("equal_dir", dir, 0);

    // Enable dropped in ACQUIRE: no capture, values retained, full settle on re-enable.
    wait_settle();
    ena              = 1'b0;
    smp.v_sample     = 8'd255;
    smp.i_sample     = 8'd255;
    smp.sample_valid = 1'b1;
    tick();
    check_eq("abort_ready", smp.sample_ready, 0);
    check_eq("abort_busy", busy, 0);
    repeat (3) begin
      tick();
      check_eq("abort_pulse", duty_update, 0);
      check_eq("abort_duty", duty, m_duty);
      check_eq("abort_power", power, m_power);
    end
    smp.sample_valid = 1'b0;
    start_run();
    run_iter(8'd150, 8'd85);

    // Rising power walks duty down into DUTY_MIN, bounces, then up into DUTY_MAX.
    for (int k = 0; k < 90; k++) run_iter(8'(150 + k), 8'd100);
    check_eq("sat_dir", dir, 0);

    for (int k = 0; k < 40; k++) run_iter(8'($urandom), 8'($urandom));

    // Reset while in COMPUTE: immediate return to reset values, captured sample lost.
    wait_settle();
    smp.v_sample     = 8'd200;
    smp.i_sample     = 8'd200;
    smp.sample_valid = 1'b1;
    tick();
    smp.sample_valid = 1'b0;
    ena = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_duty", duty, DutyInit);
    check_eq("mid_rst_power", power, 0);
    check_eq("mid_rst_dir", dir, 1);
    check_eq("mid_rst_ready", smp.sample_ready, 0);
    check_eq("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      tick();
      check_eq("post_rst_pulse", duty_update, 0);
      check_eq("post_rst_duty", duty, DutyInit);
    end

    start_run();
    run_iter(8'd150, 8'd85);
    check_eq("post_rst_dir", dir, 1);
    check_eq("post_rst_step", duty, 132);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
